// File: rtl/idli_fetch_buf.sv
// idli_fetch_buf: nibble FIFO between the SQI instruction memory and the
// decoder. Collects four nibbles (one 16b instruction, MSB nibble first) and
// then issues them to the decoder on four consecutive cycles. A redirect
// (i_flush) discards the buffered stream once any in-flight instruction has
// been delivered in full.
// Optional build macro: IDLI_FETCH_BUF_PERF_EN adds o_perf_insn_cnt, a
// saturating count of issued instructions.
module idli_fetch_buf #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        i_dcd_gck,
    input  logic        i_dcd_rst_n,
    input  logic [3:0]  i_mem_data,
    input  logic        i_mem_vld,
    output logic        o_mem_rdy,
    input  logic        i_flush,
    output logic [3:0]  o_dcd_enc,
    output logic        o_dcd_enc_vld
`ifdef IDLI_FETCH_BUF_PERF_EN
    ,
    output logic [15:0] o_perf_insn_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ISS0 = 3'd1,
        ISS1 = 3'd2,
        ISS2 = 3'd3,
        ISS3 = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [3:0]         mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_ptr_nxt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               flush_pend;
    logic               flush_pend_nxt;

    logic               issuing_c;
    logic               push_c;
    logic               pop_c;
    logic               clear_c;

    // Flow control and decoder outputs, all decoded from flopped state only.
    assign issuing_c     = (state != IDLE);
    assign o_mem_rdy     = (count < CNT_W'(DEPTH)) && !flush_pend;
    assign o_dcd_enc_vld = issuing_c;
    assign o_dcd_enc     = issuing_c ? mem[rd_ptr] : 4'b0000;

    // FIFO bookkeeping: push/pop qualification, flush clearing, next pointers.
    always_comb begin
        pop_c          = issuing_c;
        // A flush empties the buffer immediately when idle, otherwise at the
        // edge that completes the instruction currently being delivered.
        clear_c        = ((state == IDLE) && i_flush) ||
                         ((state == ISS3) && (flush_pend || i_flush));
        push_c         = i_mem_vld && o_mem_rdy && !clear_c;
        rd_ptr_nxt     = rd_ptr;
        wr_ptr_nxt     = wr_ptr;
        count_nxt      = count;
        flush_pend_nxt = flush_pend;
        if (clear_c) begin
            rd_ptr_nxt     = '0;
            wr_ptr_nxt     = '0;
            count_nxt      = '0;
            flush_pend_nxt = 1'b0;
        end else begin
            rd_ptr_nxt = rd_ptr + PTR_W'(pop_c);
            wr_ptr_nxt = wr_ptr + PTR_W'(push_c);
            count_nxt  = count + CNT_W'(push_c) - CNT_W'(pop_c);
            if (issuing_c && i_flush) begin
                flush_pend_nxt = 1'b1;
            end
        end
    end

    // Issue sequencer: start when a whole instruction is buffered, then run
    // four cycles without stalling; chain straight into the next if possible.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((count >= CNT_W'(4)) && !flush_pend && !i_flush) begin
                    state_nxt = ISS0;
                end
            end
            ISS0: state_nxt = ISS1;
            ISS1: state_nxt = ISS2;
            ISS2: state_nxt = ISS3;
            ISS3: begin
                if ((count_nxt >= CNT_W'(4)) && !flush_pend && !i_flush) begin
                    state_nxt = ISS0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointers, occupancy and pending-flush flag.
    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            flush_pend <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr_nxt;
            count      <= count_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    // Nibble storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_dcd_gck) begin
        if (push_c) begin
            mem[wr_ptr] <= i_mem_data;
        end
    end

`ifdef IDLI_FETCH_BUF_PERF_EN
    // Saturating count of instructions issued (one per ISS3 cycle).
    always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
        if (!i_dcd_rst_n) begin
            o_perf_insn_cnt <= 16'h0000;
        end else if ((state == ISS3) && (o_perf_insn_cnt != 16'hFFFF)) begin
            o_perf_insn_cnt <= o_perf_insn_cnt + 16'h0001;
        end
    end
`endif

endmodule
